// File: rtl/gearbox_pkg.sv
// Shared types and constants for the 128b/130b receive/transmit gearboxes.
// Holds the FSM state type, the legal sync headers and the default widths.
package gearbox_pkg;

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_CTRL = 2'b01;

  localparam int DEF_IN_W  = 10;
  localparam int DEF_OUT_W = 130;

  // Any header other than the two legal codes marks a corrupted or misaligned block.
  function automatic logic hdr_illegal(input logic [1:0] hdr);
    return (hdr != HDR_DATA) && (hdr != HDR_CTRL);
  endfunction

endpackage

// File: rtl/gearbox_s2p.sv
// Serial-to-parallel gearbox: packs N serial words into one block behind a
// one-entry output register, with word slip for alignment and header checking.
module gearbox_s2p
  import gearbox_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  ser_word,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             slip,
  output logic [OUT_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_hdr_err,
  output logic             busy
);

  localparam int N     = OUT_W / IN_W;
  localparam int CNT_W = $clog2(N + 1);
  localparam int ACC_W = OUT_W - IN_W;

  generate
    if ((OUT_W % IN_W) != 0 || N < 2) begin : g_bad_width
      $error("gearbox_s2p: OUT_W must be a multiple (>= 2x) of IN_W");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               drop_pend_reg, drop_pend_next;
  logic [IN_W-1:0]    acc_reg [0:N-2];
  logic [IN_W-1:0]    last_word_reg;
  logic [ACC_W-1:0]   acc_flat;
  logic [N-2:0]       word_sel;
  logic [N-2:0]       acc_we;
  logic               last_we;
  logic               load_blk;
  logic [OUT_W-1:0]   load_data;
  logic               accept;
  logic               out_free;
  logic [OUT_W-1:0]   blk_data_reg;
  logic               blk_valid_reg;
  logic               blk_hdr_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_acc
      assign acc_flat[gi*IN_W +: IN_W] = acc_reg[gi];
      assign word_sel[gi]              = (cnt_reg == CNT_W'(gi));
    end
  endgenerate

  // ser_ready is purely a function of the state register, never of blk_ready.
  assign ser_ready = (state_reg == COLLECT);
  assign accept    = ser_valid && ser_ready;
  assign out_free  = !blk_valid_reg || blk_ready;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    drop_pend_next = drop_pend_reg;
    acc_we         = '0;
    last_we        = 1'b0;
    load_blk       = 1'b0;
    load_data      = '0;
    case (state_reg)
      COLLECT: begin
        if (slip) begin
          // A word arriving with the slip is itself the dropped word.
          cnt_next       = '0;
          drop_pend_next = !accept;
        end else if (accept) begin
          if (drop_pend_reg) begin
            drop_pend_next = 1'b0;
          end else if (cnt_reg == CNT_W'(N - 1)) begin
            if (out_free) begin
              load_blk  = 1'b1;
              load_data = {ser_word, acc_flat};
              cnt_next  = '0;
            end else begin
              last_we    = 1'b1;
              cnt_next   = CNT_W'(N);
              state_next = HOLD;
            end
          end else begin
            acc_we   = word_sel;
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (blk_valid_reg && blk_ready) begin
          load_blk   = 1'b1;
          load_data  = {last_word_reg, acc_flat};
          cnt_next   = '0;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      drop_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      drop_pend_reg <= drop_pend_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N - 1; i++) acc_reg[i] <= '0;
      last_word_reg <= '0;
    end else begin
      for (int i = 0; i < N - 1; i++) begin
        if (acc_we[i]) acc_reg[i] <= ser_word;
      end
      if (last_we) last_word_reg <= ser_word;
    end
  end

  // Output register: contents only change on a load, so they stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_data_reg    <= '0;
      blk_valid_reg   <= 1'b0;
      blk_hdr_err_reg <= 1'b0;
    end else if (load_blk) begin
      blk_data_reg    <= load_data;
      blk_valid_reg   <= 1'b1;
      blk_hdr_err_reg <= hdr_illegal(load_data[1:0]);
    end else if (blk_ready) begin
      blk_valid_reg <= 1'b0;
    end
  end

  assign blk_data    = blk_data_reg;
  assign blk_valid   = blk_valid_reg;
  assign blk_hdr_err = blk_hdr_err_reg;
  assign busy        = (cnt_reg != '0) || (state_reg == HOLD) || blk_valid_reg;

endmodule

// File: doc/gearbox_s2p.md
# gearbox_s2p

Serial-to-parallel gearbox for the receive path. It collects IN_W-bit serial words into one OUT_W-bit block (default thirteen 10-bit words into one 130-bit 128b/130b block) and presents the block on a valid/ready interface with a one-block output register. It provides a word-slip input for block alignment and flags illegal 2-bit sync headers. It sits between the deserializer word stream and the block decoder, mirroring the transmit-side parallel-to-serial gearbox.

## Interface
- IN_W, 10, serial word width
- OUT_W, 130, block width; OUT_W % IN_W == 0 required (elaboration error otherwise)
- N (localparam), OUT_W/IN_W, words per block
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ser_word  in  IN_W  incoming serial word
- ser_valid  in  1  ser_word valid
- ser_ready  out  1  gearbox can accept a word this cycle
- slip  in  1  single-cycle request to shift the block boundary by one word
- blk_data  out  OUT_W  assembled block
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  downstream accepts block
- blk_hdr_err  out  1  sync header blk_data[1:0] is 2'b00 or 2'b11; qualified by blk_valid
- busy  out  1  partial block held, full block pending, or output occupied

## Operation
- Word accepted when ser_valid && ser_ready. The k-th accepted word of a block (k = 0..N-1) is placed at blk[k*IN_W +: IN_W], so word 0 carries the sync header in bits [1:0].
- The accumulator holds words 0..N-2. Counter cnt (width $clog2(N+1)) counts the words stored.
- FSM states:
  - COLLECT: ser_ready=1.
  - HOLD: full block waiting for the output register; ser_ready=0.
- On acceptance of word N-1 in COLLECT, the output register is free if blk_valid==0 or blk_ready==1 that cycle:
  - Free: blk_data <= {ser_word, acc}, blk_valid <= 1, blk_hdr_err computed from the new block, cnt <= 0, stay in COLLECT.
  - Not free: store the word, go to HOLD.
- In HOLD, when blk_valid && blk_ready: load the held block into the output register, set blk_valid=1, set cnt=0, go to COLLECT.
- When blk_valid && blk_ready and no new block is loaded, blk_valid <= 0.
- blk_data and blk_hdr_err stay stable while blk_valid && !blk_ready.
- slip in COLLECT:
  - Discard the partial block and set cnt=0.
  - Drop the next accepted word. If a word is accepted in the slip cycle itself, that word is the dropped one.
  - The dropped word is not counted.
  - A second slip while a drop is pending has no additional effect.
- slip in HOLD is ignored (the block is complete).
- busy = (cnt != 0) || (state == HOLD) || blk_valid.

## Timing
- Reset values: ser_ready=1 (state COLLECT), blk_valid=0, blk_data=0, blk_hdr_err=0, busy=0, cnt=0, no drop pending.
- Reset asserted mid-block: the partial block and any pending output are lost immediately, with no output glitch after reset deassertion.
- Latency: word N-1 accepted at cycle t gives blk_valid=1 at t+1.
- Throughput: one block per N cycles with continuous ser_valid and blk_ready=1, with no bubble on ser_ready.
- ser_ready depends only on registered state. There is no combinational path from blk_ready to ser_ready.
- HOLD exit: blk_ready at cycle t gives ser_ready=1 at t+1.
- Simultaneous output drain and new-block completion in COLLECT: the new block replaces the drained one with no idle cycle; blk_valid stays 1.

## Structure
- Package gearbox_pkg holds:
  - state_t {COLLECT, HOLD}
  - HDR_DATA=2'b10 and HDR_CTRL=2'b01
  - default IN_W/OUT_W constants, shared with gearbox_p2s
- Single module, no sub-module. The accumulator, FSM, and output register are inline.

## Test plan
- Reset, then 13 words 0x001..0x00D with ser_valid held and blk_ready=1 -> one blk_valid pulse at cycle t+1 after the last word. blk_data[9:0]=0x001 and blk_data[129:120]=0x00D. blk_hdr_err=0 (header 2'b01).
- 26 continuous words with blk_ready=1 -> two blocks 13 cycles apart; ser_ready never drops.
- blk_ready=0 for 30 cycles with continuous input -> first block held stable. Second block fills and the FSM enters HOLD with ser_ready=0. After blk_ready=1 for one cycle, the second block appears, and ser_ready=1 on the next cycle.
- slip pulsed after 5 words -> those 5 words are discarded and the next word is dropped. The following 13 words form the block, and busy=0 after drain.
- First word 0x000 (header 2'b00) -> blk_hdr_err=1 with blk_valid. First word 0x003 -> blk_hdr_err=1. First word 0x002 -> 0.
- rst asserted after 7 words, then released -> blk_valid=0. The next 13 words form a clean block with no leftover data.
